// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables and selects, with wait states on a shared memory.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
    } state_t;

    state_t state, next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= next;
    end

    always_comb begin
        next       = state;
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcen       = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b010;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state)
            FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcen    = mem_ready;
                if (mem_ready) next = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    6'b100011, 6'b101011: next = MEMADR;
                    6'b000000:            next = RTYPEEX;
                    6'b000100:            next = BEQEX;
                    6'b001000:            next = ADDIEX;
                    6'b000010:            next = JEX;
                    default: begin
                        illegal = 1'b1;
                        next    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                next    = (op == 6'b100011) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) next = MEMWB;
            end
            MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
                next       = FETCH;
            end
            MEMWR: begin
                mem_req    = 1'b1;
                memwrite   = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) next = FETCH;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                next    = RTYPEWB;
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default: begin
                        illegal = 1'b1;
                        next    = FETCH;
                    end
                endcase
            end
            RTYPEWB: begin
                regwrite   = 1'b1;
                regdst     = 1'b1;
                instr_done = 1'b1;
                next       = FETCH;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                pcen       = zero;
                instr_done = 1'b1;
                next       = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                next    = ADDIWB;
            end
            ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                next       = FETCH;
            end
            JEX: begin
                pcsrc      = 2'b10;
                pcen       = 1'b1;
                instr_done = 1'b1;
                next       = FETCH;
            end
            default: next = FETCH;
        endcase

        // Reset overrides the FETCH Moore outputs so nothing fires while held.
        if (!reset) begin
            mem_req    = 1'b0;
            memwrite   = 1'b0;
            iord       = 1'b0;
            irwrite    = 1'b0;
            pcen       = 1'b0;
            regwrite   = 1'b0;
            regdst     = 1'b0;
            memtoreg   = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = 2'b00;
            pcsrc      = 2'b00;
            alucontrol = 3'b010;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed cycle-by-cycle vector bench for mc_controller, plus an
// asynchronous-reset-mid-instruction sequence.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       instr_done, illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite),
        .iord(iord), .irwrite(irwrite), .pcen(pcen), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .instr_done(instr_done), .illegal(illegal)
    );

    // Field order: mem_req memwrite iord irwrite pcen regwrite regdst memtoreg
    //              alusrca alusrcb pcsrc alucontrol instr_done illegal
    function automatic logic [18:0] o(input logic mr, mw, io, irw, pce, rw, rd, m2r, asa,
                                      input logic [1:0] asb, pcs, input logic [2:0] alu,
                                      input logic dn, ill);
        return {mr, mw, io, irw, pce, rw, rd, m2r, asa, asb, pcs, alu, dn, ill};
    endfunction

    wire [18:0] got = {mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg,
                       alusrca, alusrcb, pcsrc, alucontrol, instr_done, illegal};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                           BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BADOP = 6'b111111;

    typedef struct {
        string       name;
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        rdy;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic r, input logic [5:0] o_, f,
                       input logic z, rd, input logic [18:0] e);
        vec_t v;
        v.name = n; v.rst = r; v.op = o_; v.funct = f; v.zero = z; v.rdy = rd; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [18:0] e);
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", n, got, e);
        end
    endtask

    logic [18:0] E_RST, F_RDY, F_WAIT, DEC, DEC_ILL, MADR, MRD, MWB, MWR_W, MWR_R,
                 RTEX_SLT, RTEX_SUB, RTEX_ILL, RTWB, BEQ1, BEQ0, AEX, AWB, JX;

    initial begin
        E_RST    = o(0,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b010,0,0);
        F_RDY    = o(1,0,0,1,1,0,0,0,0,2'b01,2'b00,3'b010,0,0);
        F_WAIT   = o(1,0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,0);
        DEC      = o(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0);
        DEC_ILL  = o(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,1);
        MADR     = o(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0);
        MRD      = o(1,0,1,0,0,0,0,0,0,2'b00,2'b00,3'b010,0,0);
        MWB      = o(0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b010,1,0);
        MWR_W    = o(1,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b010,0,0);
        MWR_R    = o(1,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b010,1,0);
        RTEX_SLT = o(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b111,0,0);
        RTEX_SUB = o(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b110,0,0);
        RTEX_ILL = o(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b010,0,1);
        RTWB     = o(0,0,0,0,0,1,1,0,0,2'b00,2'b00,3'b010,1,0);
        BEQ1     = o(0,0,0,0,1,0,0,0,1,2'b00,2'b01,3'b110,1,0);
        BEQ0     = o(0,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,1,0);
        AEX      = o(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0);
        AWB      = o(0,0,0,0,0,1,0,0,0,2'b00,2'b00,3'b010,1,0);
        JX       = o(0,0,0,0,1,0,0,0,0,2'b00,2'b10,3'b010,1,0);

        for (int i = 0; i < 3; i++) add("reset", 0, LW, 0, 0, 1, E_RST);
        add("lw_fetch", 1, LW, 0, 0, 1, F_RDY);
        add("lw_dec",   1, LW, 0, 0, 1, DEC);
        add("lw_madr",  1, LW, 0, 0, 1, MADR);
        add("lw_mrd",   1, LW, 0, 0, 1, MRD);
        add("lw_mwb",   1, LW, 0, 0, 1, MWB);
        add("sw_fetch", 1, SW, 0, 0, 1, F_RDY);
        add("sw_dec",   1, SW, 0, 0, 1, DEC);
        add("sw_madr",  1, SW, 0, 0, 1, MADR);
        add("sw_wait1", 1, SW, 0, 0, 0, MWR_W);
        add("sw_wait2", 1, SW, 0, 0, 0, MWR_W);
        add("sw_done",  1, SW, 0, 0, 1, MWR_R);
        add("slt_fetch",1, RT, 6'b101010, 0, 1, F_RDY);
        add("slt_dec",  1, RT, 6'b101010, 0, 1, DEC);
        add("slt_ex",   1, RT, 6'b101010, 0, 1, RTEX_SLT);
        add("slt_wb",   1, RT, 6'b101010, 0, 1, RTWB);
        add("sub_fetch",1, RT, 6'b100010, 0, 1, F_RDY);
        add("sub_dec",  1, RT, 6'b100010, 0, 0, DEC);
        add("sub_ex",   1, RT, 6'b100010, 0, 0, RTEX_SUB);
        add("sub_wb",   1, RT, 6'b100010, 0, 0, RTWB);
        add("rill_fetch",1, RT, 6'b000000, 0, 1, F_RDY);
        add("rill_dec", 1, RT, 6'b000000, 0, 1, DEC);
        add("rill_ex",  1, RT, 6'b000000, 0, 1, RTEX_ILL);
        add("beq1_fetch",1, BEQ, 0, 1, 1, F_RDY);
        add("beq1_dec", 1, BEQ, 0, 1, 1, DEC);
        add("beq1_ex",  1, BEQ, 0, 1, 1, BEQ1);
        add("beq0_fetch",1, BEQ, 0, 0, 1, F_RDY);
        add("beq0_dec", 1, BEQ, 0, 0, 1, DEC);
        add("beq0_ex",  1, BEQ, 0, 0, 1, BEQ0);
        for (int i = 0; i < 4; i++) add("addi_fwait", 1, ADDI, 0, 0, 0, F_WAIT);
        add("addi_fetch",1, ADDI, 0, 0, 1, F_RDY);
        add("addi_dec", 1, ADDI, 0, 0, 0, DEC);
        add("addi_ex",  1, ADDI, 0, 0, 0, AEX);
        add("addi_wb",  1, ADDI, 0, 0, 0, AWB);
        add("j_fetch",  1, J, 0, 0, 1, F_RDY);
        add("j_dec",    1, J, 0, 0, 1, DEC);
        add("j_ex",     1, J, 0, 0, 1, JX);
        add("ill_fetch",1, BADOP, 0, 0, 1, F_RDY);
        add("ill_dec",  1, BADOP, 0, 0, 1, DEC_ILL);
        add("after_ill",1, LW, 0, 0, 1, F_RDY);

        // Inputs change 1 time unit after a rising edge; outputs checked mid-cycle.
        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].funct;
            zero = vecs[i].zero; mem_ready = vecs[i].rdy;
            #3;
            check(vecs[i].name, vecs[i].exp);
            @(posedge clk); #1;
        end

        // Reset mid-lw (state currently DECODE of lw after after_ill's fetch).
        op = LW; mem_ready = 1'b1;
        #3 check("mid_dec", DEC);
        @(posedge clk); #1 check("mid_madr", MADR);
        @(posedge clk); #1 check("mid_mrd", MRD);
        reset = 1'b0;
        #1 check("async_reset", E_RST);
        @(posedge clk); #1 check("held_reset", E_RST);
        reset = 1'b1;
        #1 check("restart_fetch", F_RDY);
        @(posedge clk); #1 check("restart_dec", DEC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
